// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: shared FSM state type and default timing constants for the ADC conversion sequencer.
package adc_seq_pkg;
   typedef enum logic [1:0] {IDLE, CONV, READ, DONE} state_t;
   localparam int DEF_CONV_CYCLES    = 40;
   localparam int DEF_TIMEOUT_CYCLES = 1023;
endpackage

// File: rtl/adc_seq_timer.sv
// adc_seq_timer: loadable down-counter that saturates at zero and flags when it has run out.
module adc_seq_timer #(
   parameter int W = 16
) (
   input  logic         clk_adc,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_value,
   output logic         o_zero
);
   logic [W-1:0] r_cnt;
   always_ff @(posedge clk_adc or negedge rst_n)
      if (!rst_n)
         r_cnt <= '0;
      else if (i_load)
         r_cnt <= i_value;
      else if (r_cnt != '0)
         r_cnt <= r_cnt - W'(1);
   assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/adc_conv_sequencer.sv
// adc_conv_sequencer: schedules ADC conversions, requests the SPI read-back and delivers samples.
// Define ADC_SEQ_AVG_EN to deliver the average of every 4 captured words instead of each word.
module adc_conv_sequencer
   import adc_seq_pkg::*;
#(
   parameter int DATA_WIDTH     = 16,
   parameter int CONV_CYCLES    = DEF_CONV_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                  clk_adc,
   input  logic                  rst_n,
   input  logic                  enable_i,
   input  logic [15:0]           period_i,
   output logic                  adc_cnv_n_o,
   output logic                  spi_rd_req_o,
   input  logic [DATA_WIDTH-1:0] spi_data_i,
   input  logic                  spi_valid_i,
   output logic [DATA_WIDTH-1:0] sample_data_o,
   output logic                  sample_valid_o,
   output logic [15:0]           sample_cnt_o,
   output logic                  timeout_o,
   output logic                  busy_o
);
   localparam logic [15:0] CONV_LD = 16'(CONV_CYCLES - 1);
   localparam logic [15:0] TMO_LD  = 16'(TIMEOUT_CYCLES - 1);
   state_t                r_state, w_next;
   logic                  w_start, w_per_zero, w_tmr_load, w_tmr_zero;
   logic                  w_capture, w_timeout, w_deliver;
   logic [15:0]           w_per_value, w_tmr_value;
   logic [DATA_WIDTH-1:0] w_result;
   logic [DATA_WIDTH-1:0] r_data;
   logic [15:0]           r_cnt;
   logic                  r_valid, r_timeout, r_rd_req;
   // The period counter expires one cycle early so start-to-start spacing equals period_i.
   assign w_per_value = (period_i == 16'd0) ? 16'd0 : period_i - 16'd1;
   adc_seq_timer #(.W(16)) u_period (
      .clk_adc (clk_adc),
      .rst_n   (rst_n),
      .i_load  (w_start),
      .i_value (w_per_value),
      .o_zero  (w_per_zero)
   );
   // One timer serves both the conversion hold time and the read timeout.
   adc_seq_timer #(.W(16)) u_tmo (
      .clk_adc (clk_adc),
      .rst_n   (rst_n),
      .i_load  (w_tmr_load),
      .i_value (w_tmr_value),
      .o_zero  (w_tmr_zero)
   );
   always_ff @(posedge clk_adc or negedge rst_n)
      if (!rst_n)
         r_state <= IDLE;
      else
         r_state <= w_next;
   always_comb begin
      w_next      = r_state;
      w_start     = 1'b0;
      w_tmr_load  = 1'b0;
      w_tmr_value = '0;
      w_capture   = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         IDLE: if (enable_i && w_per_zero) begin
            w_next      = CONV;
            w_start     = 1'b1;
            w_tmr_load  = 1'b1;
            w_tmr_value = CONV_LD;
         end
         CONV: if (w_tmr_zero) begin
            w_next      = READ;
            w_tmr_load  = 1'b1;
            w_tmr_value = TMO_LD;
         end
         READ: if (spi_valid_i) begin
            w_next    = DONE;
            w_capture = 1'b1;
         end else if (w_tmr_zero) begin
            w_next    = IDLE;
            w_timeout = 1'b1;
         end
         default: w_next = IDLE;
      endcase
   end
`ifdef ADC_SEQ_AVG_EN
   localparam int AW = DATA_WIDTH + 2;
   logic [AW-1:0] r_acc, w_sum;
   logic [1:0]    r_grp;
   assign w_sum     = r_acc + AW'(spi_data_i);
   assign w_deliver = w_capture && (r_grp == 2'd3);
   assign w_result  = w_sum[AW-1:2];
   always_ff @(posedge clk_adc or negedge rst_n)
      if (!rst_n) begin
         r_acc <= '0;
         r_grp <= '0;
      end else if (w_timeout || w_deliver) begin
         r_acc <= '0;
         r_grp <= '0;
      end else if (w_capture) begin
         r_acc <= w_sum;
         r_grp <= r_grp + 2'd1;
      end
`else
   assign w_deliver = w_capture;
   assign w_result  = spi_data_i;
`endif
   always_ff @(posedge clk_adc or negedge rst_n)
      if (!rst_n) begin
         r_data    <= '0;
         r_cnt     <= '0;
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
         r_rd_req  <= 1'b0;
      end else begin
         r_rd_req <= (r_state == CONV) && w_tmr_zero;
         r_valid  <= w_deliver;
         if (w_deliver) begin
            r_data <= w_result;
            r_cnt  <= r_cnt + 16'd1;
         end
         if (w_timeout)
            r_timeout <= 1'b1;
      end
   assign adc_cnv_n_o    = (r_state != CONV);
   assign busy_o         = (r_state != IDLE);
   assign spi_rd_req_o   = r_rd_req;
   assign sample_valid_o = r_valid;
   assign sample_data_o  = r_data;
   assign sample_cnt_o   = r_cnt;
   assign timeout_o      = r_timeout;
endmodule

// File: tb/tb_adc_conv_sequencer.sv
// tb_adc_conv_sequencer: directed scenarios with a cycle-age reference model checked every cycle.
module tb_adc_conv_sequencer;
   localparam int DW = 16;
   localparam int C  = 40;
   localparam int T  = 1023;
   logic          clk_adc = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable_i = 1'b0;
   logic [15:0]   period_i = 16'd0;
   logic          adc_cnv_n_o, spi_rd_req_o, sample_valid_o, timeout_o, busy_o;
   logic [DW-1:0] spi_data_i = '0;
   logic          spi_valid_i = 1'b0;
   logic [DW-1:0] sample_data_o;
   logic [15:0]   sample_cnt_o;
   int n_err = 0, n_chk = 0, tb_cyc = 0;
   int spi_delay = 20;
   bit spi_silent = 1'b0;
   logic [DW-1:0] words[$];

   adc_conv_sequencer #(.DATA_WIDTH(DW), .CONV_CYCLES(C), .TIMEOUT_CYCLES(T)) dut (
      .clk_adc(clk_adc), .rst_n(rst_n), .enable_i(enable_i), .period_i(period_i),
      .adc_cnv_n_o(adc_cnv_n_o), .spi_rd_req_o(spi_rd_req_o), .spi_data_i(spi_data_i),
      .spi_valid_i(spi_valid_i), .sample_data_o(sample_data_o), .sample_valid_o(sample_valid_o),
      .sample_cnt_o(sample_cnt_o), .timeout_o(timeout_o), .busy_o(busy_o));

   always #5 clk_adc = ~clk_adc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", name, tb_cyc, act, exp);
      end
   endtask

   // Reference model: a conversion is described by its age in cycles since its first low-strobe cycle.
   bit m_act, m_done, m_valid, m_to;
   int m_age, m_next_ok, m_grp, m_sum;
   logic [15:0] m_cnt;
   logic [DW-1:0] m_data;
   logic s_rst, s_en, s_val;
   logic [15:0] s_per;
   logic [DW-1:0] s_dat;

   task model_deliver(input logic [DW-1:0] w);
`ifdef ADC_SEQ_AVG_EN
      m_sum += int'(w);
      m_grp++;
      if (m_grp == 4) begin
         m_data = DW'(m_sum / 4);
         m_valid = 1'b1;
         m_cnt++;
         m_sum = 0;
         m_grp = 0;
      end
`else
      m_data = w;
      m_valid = 1'b1;
      m_cnt++;
`endif
   endtask

   task model_step();
      if (!s_rst) begin
         m_act = 0; m_done = 0; m_valid = 0; m_to = 0; m_age = 0;
         m_next_ok = 0; m_grp = 0; m_sum = 0; m_cnt = 0; m_data = 0;
      end else begin
         m_valid = 0;
         if (!m_act) begin
            if (s_en && tb_cyc >= m_next_ok) begin
               m_act = 1; m_age = 0; m_next_ok = tb_cyc + int'(s_per);
            end
         end else if (m_done) begin
            m_act = 0; m_done = 0;
         end else if (m_age < C) begin
            m_age++;
         end else if (s_val) begin
            m_done = 1;
            model_deliver(s_dat);
         end else if (m_age == C + T - 1) begin
            m_act = 0; m_to = 1; m_sum = 0; m_grp = 0;
         end else begin
            m_age++;
         end
      end
   endtask

   initial forever begin
      @(posedge clk_adc);
      tb_cyc++;
      s_rst = rst_n; s_en = enable_i; s_per = period_i; s_val = spi_valid_i; s_dat = spi_data_i;
      model_step();
      #1;
      check("cnv_n", adc_cnv_n_o, !(m_act && !m_done && m_age < C));
      check("rd_req", spi_rd_req_o, m_act && !m_done && m_age == C);
      check("busy", busy_o, m_act);
      check("valid", sample_valid_o, m_valid);
      check("data", sample_data_o, m_data);
      check("cnt", sample_cnt_o, m_cnt);
      check("timeout", timeout_o, m_to);
   end

   // SPI reader stand-in: answers a read request spi_delay cycles later unless silenced.
   initial forever begin
      @(posedge clk_adc);
      #1;
      if (spi_rd_req_o && !spi_silent) begin
         repeat (spi_delay) @(posedge clk_adc);
         @(negedge clk_adc);
         spi_data_i = (words.size() > 0) ? words.pop_front() : 16'h1234;
         spi_valid_i = 1'b1;
         @(negedge clk_adc);
         spi_valid_i = 1'b0;
      end
   end

   task automatic wait_fall(input string name, output int t);
      int i;
      for (i = 0; i < 1200 && !adc_cnv_n_o; i++) @(negedge clk_adc);
      for (i = 0; i < 1200 && adc_cnv_n_o; i++) @(negedge clk_adc);
      if (adc_cnv_n_o) check({name, "_no_start"}, 1, 0);
      t = tb_cyc;
   endtask

   task automatic wait_rd(output int t);
      for (int i = 0; i < 200 && !spi_rd_req_o; i++) @(negedge clk_adc);
      if (!spi_rd_req_o) check("rd_req_wait", 0, 1);
      t = tb_cyc;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 1200 && busy_o; i++) @(negedge clk_adc);
      if (busy_o) check("idle_wait", 1, 0);
   endtask

   initial begin
      int t0, t1, t2, n;
      logic [15:0] c0;
      repeat (3) @(negedge clk_adc);
      check("rst_cnv_n", adc_cnv_n_o, 1);
      check("rst_busy", busy_o, 0);
      check("rst_cnt", sample_cnt_o, 0);
      rst_n = 1'b1;
      @(negedge clk_adc);
      // Periodic conversions, 100-cycle spacing, SPI answers 20 cycles after the request.
      period_i = 16'd100;
      enable_i = 1'b1;
      t0 = tb_cyc;
      wait_fall("a0", t1);
      check("first_start_lat", t1 - t0, 1);
      for (int i = 0; i < 200 && adc_cnv_n_o == 1'b0; i++) @(negedge clk_adc);
      check("low_len", tb_cyc - t1, C);
      for (int i = 0; i < 100 && !sample_valid_o; i++) @(negedge clk_adc);
      check("sample_1234", sample_data_o, 16'h1234);
      check("sample_at", tb_cyc - t1, 61);
      @(negedge clk_adc);
      check("valid_1cyc", sample_valid_o, 0);
      wait_fall("a1", t2);
      check("period_100", t2 - t1, 100);
      // Switching to back-to-back only affects the conversion after the one now running.
      period_i = 16'd0;
      wait_fall("b0", t1);
      check("period_latched", t1 - t2, 100);
      c0 = sample_cnt_o;
      wait_fall("b1", t2);
      check("b2b_gap", t2 - t1, 63);
      check("cnt_step", sample_cnt_o - c0, 1);
      // Silent SPI reader: timeout after 1023 read cycles, next conversion still follows.
      spi_silent = 1'b1;
      c0 = sample_cnt_o;
      wait_rd(t0);
      for (int i = 0; i < 1100 && !timeout_o; i++) @(negedge clk_adc);
      check("timeout_at", tb_cyc - t0, T);
      wait_fall("c0", t1);
      check("after_timeout_start", t1 - t0, T + 1);
      check("no_sample_on_timeout", sample_cnt_o, c0);
      spi_silent = 1'b0;
      // Dropping enable in the 10th strobe cycle lets that conversion finish.
      wait_fall("d0", t1);
      c0 = sample_cnt_o;
      repeat (9) @(negedge clk_adc);
      enable_i = 1'b0;
      wait_idle();
      check("drop_en_one_sample", sample_cnt_o - c0, 1);
      n = 0;
      repeat (150) begin
         @(negedge clk_adc);
         n += int'(!adc_cnv_n_o) + int'(busy_o);
      end
      check("drop_en_quiet", n, 0);
      // Reset in the middle of a read; the late SPI answer must be ignored.
      enable_i = 1'b1;
      wait_rd(t0);
      repeat (2) @(posedge clk_adc);
      #3 rst_n = 1'b0;
      #1;
      check("rst_now_cnv_n", adc_cnv_n_o, 1);
      check("rst_now_rd_req", spi_rd_req_o, 0);
      check("rst_now_busy", busy_o, 0);
      check("rst_now_cnt", sample_cnt_o, 0);
      check("rst_now_data", sample_data_o, 0);
      check("rst_now_timeout", timeout_o, 0);
      check("rst_now_valid", sample_valid_o, 0);
      @(negedge clk_adc);
      enable_i = 1'b0;
      repeat (3) @(negedge clk_adc);
      rst_n = 1'b1;
      n = 0;
      repeat (40) begin
         @(negedge clk_adc);
         n += int'(sample_valid_o);
      end
      check("late_valid_ignored", n, 0);
      check("late_valid_cnt", sample_cnt_o, 0);
      // Four words 10,20,30,41 back to back.
      words = '{16'd10, 16'd20, 16'd30, 16'd41};
      enable_i = 1'b1;
      t0 = tb_cyc;
      wait_fall("w0", t1);
      check("restart_lat", t1 - t0, 1);
`ifdef ADC_SEQ_AVG_EN
      for (int i = 0; i < 600 && sample_cnt_o != 16'd1; i++) @(negedge clk_adc);
      enable_i = 1'b0;
      check("avg_data", sample_data_o, 25);
      check("avg_cnt", sample_cnt_o, 1);
`else
      for (int i = 0; i < 600 && sample_cnt_o != 16'd4; i++) @(negedge clk_adc);
      enable_i = 1'b0;
      check("raw_data", sample_data_o, 41);
      check("raw_cnt", sample_cnt_o, 4);
`endif
      wait_idle();
      repeat (5) @(negedge clk_adc);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/adc_conv_sequencer.md
ADC_CONV_SEQUENCER -- requirements
Module: adc_conv_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, ADC sample width.
REQ-002 The block SHALL have parameter CONV_CYCLES, default 40, clk_adc cycles that adc_cnv_n_o is held low per conversion.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1023, maximum clk_adc cycles to wait for spi_valid_i.
REQ-004 Port: clk_adc  in  1  single clock for the block.
REQ-005 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Port: enable_i  in  1  level; high permits conversions to be scheduled.
REQ-007 Port: period_i  in  16  clk_adc cycles between conversion starts; 0 means back-to-back.
REQ-008 Port: adc_cnv_n_o  out  1  ADC convert strobe, active-low.
REQ-009 Port: spi_rd_req_o  out  1  one-cycle read request to the SPI reader (drives its sdi_ready_i).
REQ-010 Port: spi_data_i  in  DATA_WIDTH  SPI reader output word.
REQ-011 Port: spi_valid_i  in  1  one-cycle strobe, spi_data_i valid.
REQ-012 Port: sample_data_o  out  DATA_WIDTH  last delivered sample, held between updates.
REQ-013 Port: sample_valid_o  out  1  one-cycle strobe, sample_data_o updated.
REQ-014 Port: sample_cnt_o  out  16  delivered-sample count, wraps 0xFFFF->0.
REQ-015 Port: timeout_o  out  1  sticky; set on SPI read timeout, cleared only by reset.
REQ-016 Port: busy_o  out  1  high whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, CONV, READ and DONE.
REQ-018 A free-running period counter SHALL load period_i at every conversion start and decrement to 0, saturating at 0.
REQ-019 IDLE->CONV SHALL occur when enable_i=1 and the period counter is 0; adc_cnv_n_o goes low in the first CONV cycle.
REQ-020 CONV SHALL last exactly CONV_CYCLES cycles, then go to READ with adc_cnv_n_o high and spi_rd_req_o=1 for exactly the first READ cycle.
REQ-021 In READ, spi_valid_i=1 SHALL capture spi_data_i and go to DONE; spi_valid_i outside READ SHALL be ignored.
REQ-022 If TIMEOUT_CYCLES elapse in READ without spi_valid_i, the FSM SHALL set timeout_o, deliver no sample and return to IDLE.
REQ-023 DONE SHALL last one cycle, pulse sample_valid_o with sample_data_o updated in the same cycle, increment sample_cnt_o, and return to IDLE.
REQ-024 Dropping enable_i mid-conversion SHALL NOT abort it; the current conversion completes and no new one starts.
REQ-025 If period_i is shorter than one full conversion, the next start SHALL occur in the cycle after the return to IDLE.
REQ-026 A change to period_i SHALL take effect at the next conversion start only.

Reset
REQ-027 Asserting rst_n low SHALL immediately force IDLE, adc_cnv_n_o=1, spi_rd_req_o=0, sample_valid_o=0, sample_data_o=0, sample_cnt_o=0, timeout_o=0, busy_o=0 and period counter=0, including mid-conversion.
REQ-028 After reset release, the first conversion SHALL start in the first cycle with enable_i=1.

Configuration
REQ-029 With ADC_SEQ_AVG_EN defined, each group of 4 captured words SHALL be summed in a DATA_WIDTH+2 accumulator and delivered as sum>>2 only on every 4th capture, with sample_cnt_o counting deliveries; a timeout SHALL clear the accumulator and the group count.
REQ-030 Without ADC_SEQ_AVG_EN, every captured word SHALL be delivered unmodified and no accumulator SHALL exist.

Structure
REQ-031 Package adc_seq_pkg SHALL hold the state enum and the default CONV_CYCLES and TIMEOUT_CYCLES constants.
REQ-032 The period and timeout down-counting SHALL be implemented in one sub-module, adc_seq_timer, instanced twice.

Verification
REQ-033 period_i=100, enable_i=1, SPI model returns 0x1234 after 20 cycles -> adc_cnv_n_o low exactly 40 cycles; starts every 100 cycles; sample_data_o=0x1234 with one-cycle sample_valid_o.
REQ-034 period_i=0 -> back-to-back conversions, start one cycle after the DONE->IDLE transition; sample_cnt_o increments by 1 per sample.
REQ-035 SPI model silent -> timeout_o set after 1023 READ cycles, no sample_valid_o, next conversion still starts.
REQ-036 enable_i dropped in CONV cycle 10 -> conversion completes, one sample delivered, then busy_o=0 with no further adc_cnv_n_o pulses.
REQ-037 rst_n asserted in READ -> all outputs at reset values in the same cycle; a later spi_valid_i produces no sample.
REQ-038 ADC_SEQ_AVG_EN defined, words 10,20,30,41 -> one delivery of 25, sample_cnt_o=1.
